// File: rtl/pipe_pkg.sv
// =============================================================================
// Module   : pipe_pkg
// Purpose  : Shared constants, state encodings and producer-match helper.
// Revision : 1.0
// =============================================================================
`default_nettype none

package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // $0 is hard-wired, so a write to it never produces a forwardable value.
  function automatic logic reg_match(input logic       we,
                                     input logic [4:0] wr,
                                     input logic [4:0] src);
    return we && (wr != REG_ZERO) && (wr == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_muldiv_seq.sv
// =============================================================================
// Module   : muldiv_seq
// Purpose  : IDLE/BUSY sequencer for the multi-cycle mul/div unit.
// Revision : 1.0
// =============================================================================
`default_nettype none

module muldiv_seq
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy,
  output logic o_done
);

  localparam logic [3:0] c_CNT_LOAD = 4'(MULDIV_LAT - 1);

  md_state_e  r_state;
  md_state_e  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_done;
  logic       w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // A start seen while BUSY is dropped; the ID-stage stall normally prevents it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = c_CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign o_busy = (r_state == ST_BUSY);
  assign o_done = r_done;

  a_no_start_when_busy : assert property (
    @(posedge clk) disable iff (!rst_n) !(i_start && (r_state == ST_BUSY))
  );

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// =============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush/forwarding control with mul/div sequencing.
// Revision : 1.0
// =============================================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic [4:0]       Rs_E,
  input  logic [4:0]       Rt_E,
  input  logic [4:0]       WriteReg_E,
  input  logic [4:0]       WriteReg_M,
  input  logic [4:0]       WriteReg_W,
  input  logic             RegWrite_E,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             MemtoReg_E,
  input  logic             MemtoReg_M,
  input  logic             Branch_D,
  input  logic             PCSrc_D,
  input  logic             Jump_D,
  input  logic             MulDivStart_D,
  input  logic             MulDivStart_E,
  input  logic             HiLoRead_D,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             MulDivBusy,
  output logic             MulDivDone,
  output logic [CNT_W-1:0] StallCount
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic             w_ex_d;
  logic             w_mem_d;
  logic             w_lwstall;
  logic             w_brstall;
  logic             w_mdstall;
  logic             w_stall;
  logic             w_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  muldiv_seq #(
    .MULDIV_LAT (MULDIV_LAT)
  ) u_muldiv_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (MulDivStart_E),
    .o_busy  (w_busy),
    .o_done  (MulDivDone)
  );

  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (reg_match(RegWrite_M, WriteReg_M, Rs_E)) begin
      ForwardAE = FWD_MEM;
    end else if (reg_match(RegWrite_W, WriteReg_W, Rs_E)) begin
      ForwardAE = FWD_WB;
    end
    if (reg_match(RegWrite_M, WriteReg_M, Rt_E)) begin
      ForwardBE = FWD_MEM;
    end else if (reg_match(RegWrite_W, WriteReg_W, Rt_E)) begin
      ForwardBE = FWD_WB;
    end
  end

  assign ForwardAD = reg_match(RegWrite_M, WriteReg_M, Rs_D);
  assign ForwardBD = reg_match(RegWrite_M, WriteReg_M, Rt_D);

  // Branches compare in ID, so any result not yet in MEM as an ALU value blocks them.
  assign w_ex_d    = reg_match(RegWrite_E, WriteReg_E, Rs_D) |
                     reg_match(RegWrite_E, WriteReg_E, Rt_D);
  assign w_mem_d   = reg_match(RegWrite_M, WriteReg_M, Rs_D) |
                     reg_match(RegWrite_M, WriteReg_M, Rt_D);
  assign w_lwstall = MemtoReg_E & w_ex_d;
  assign w_brstall = Branch_D & (w_ex_d | (MemtoReg_M & w_mem_d));
  assign w_mdstall = w_busy & (HiLoRead_D | MulDivStart_D);
  assign w_stall   = w_lwstall | w_brstall | w_mdstall;

  assign StallF     = w_stall;
  assign StallD     = w_stall;
  assign FlushE     = w_stall;
  assign FlushD     = (PCSrc_D | Jump_D) & ~w_stall;
  assign MulDivBusy = w_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// =============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed plus random checks of hazard_ctrl against a spec model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_hazard_ctrl;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M;
  logic       Branch_D, PCSrc_D, Jump_D, MulDivStart_D, MulDivStart_E, HiLoRead_D;

  logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MulDivBusy, MulDivDone;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  logic        StallF_b, StallD_b, FlushD_b, FlushE_b, ForwardAD_b, ForwardBD_b;
  logic        MulDivBusy_b, MulDivDone_b;
  logic [1:0]  ForwardAE_b, ForwardBE_b;
  logic [3:0]  StallCount_b;

  int total = 0;
  int bad   = 0;

  int m_busy_left = 0;
  bit m_done      = 1'b0;
  int m_cnt       = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .Branch_D(Branch_D),
    .PCSrc_D(PCSrc_D), .Jump_D(Jump_D), .MulDivStart_D(MulDivStart_D),
    .MulDivStart_E(MulDivStart_E), .HiLoRead_D(HiLoRead_D),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone),
    .StallCount(StallCount)
  );

  hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
    .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
    .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .Branch_D(Branch_D),
    .PCSrc_D(PCSrc_D), .Jump_D(Jump_D), .MulDivStart_D(MulDivStart_D),
    .MulDivStart_E(MulDivStart_E), .HiLoRead_D(HiLoRead_D),
    .StallF(StallF_b), .StallD(StallD_b), .FlushD(FlushD_b), .FlushE(FlushE_b),
    .ForwardAE(ForwardAE_b), .ForwardBE(ForwardBE_b), .ForwardAD(ForwardAD_b),
    .ForwardBD(ForwardBD_b), .MulDivBusy(MulDivBusy_b), .MulDivDone(MulDivDone_b),
    .StallCount(StallCount_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pm(input bit we, input logic [4:0] wr, input logic [4:0] s);
    return we && (wr != 5'd0) && (wr == s);
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] s);
    if (pm(RegWrite_M, WriteReg_M, s)) return 2'b10;
    if (pm(RegWrite_W, WriteReg_W, s)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    bit ex_hit, mem_hit;
    ex_hit  = pm(RegWrite_E, WriteReg_E, Rs_D) || pm(RegWrite_E, WriteReg_E, Rt_D);
    mem_hit = pm(RegWrite_M, WriteReg_M, Rs_D) || pm(RegWrite_M, WriteReg_M, Rt_D);
    return (MemtoReg_E && ex_hit) ||
           (Branch_D && (ex_hit || (MemtoReg_M && mem_hit))) ||
           ((m_busy_left > 0) && (HiLoRead_D || MulDivStart_D));
  endfunction

  task automatic check_all();
    bit s;
    s = m_stall();
    chk("StallF", 32'(StallF), 32'(s));
    chk("StallD", 32'(StallD), 32'(s));
    chk("FlushE", 32'(FlushE), 32'(s));
    chk("FlushD", 32'(FlushD), 32'((PCSrc_D || Jump_D) && !s));
    chk("ForwardAE", 32'(ForwardAE), 32'(m_fwd(Rs_E)));
    chk("ForwardBE", 32'(ForwardBE), 32'(m_fwd(Rt_E)));
    chk("ForwardAD", 32'(ForwardAD), 32'(pm(RegWrite_M, WriteReg_M, Rs_D)));
    chk("ForwardBD", 32'(ForwardBD), 32'(pm(RegWrite_M, WriteReg_M, Rt_D)));
    chk("MulDivBusy", 32'(MulDivBusy), 32'(m_busy_left > 0));
    chk("MulDivDone", 32'(MulDivDone), 32'(m_done));
    chk("StallCount", 32'(StallCount), 32'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("StallCount4", 32'(StallCount_b), 32'((m_cnt > 15) ? 15 : m_cnt));
    chk("MulDivBusy4", 32'(MulDivBusy_b), 32'(m_busy_left > 0));
  endtask

  // Called just after a falling edge: let inputs settle, then check.
  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    @(posedge clk);
    if (s) m_cnt++;
    if (m_busy_left > 0) begin
      m_busy_left--;
      m_done = (m_busy_left == 0);
    end else begin
      m_done = 1'b0;
      if (MulDivStart_E) m_busy_left = LAT;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Rs_D = 5'd0; Rt_D = 5'd0; Rs_E = 5'd0; Rt_E = 5'd0;
    WriteReg_E = 5'd0; WriteReg_M = 5'd0; WriteReg_W = 5'd0;
    RegWrite_E = 1'b0; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    MemtoReg_E = 1'b0; MemtoReg_M = 1'b0; Branch_D = 1'b0; PCSrc_D = 1'b0;
    Jump_D = 1'b0; MulDivStart_D = 1'b0; MulDivStart_E = 1'b0; HiLoRead_D = 1'b0;
  endtask

  task automatic model_reset();
    m_busy_left = 0;
    m_done      = 1'b0;
    m_cnt       = 0;
  endtask

  initial begin
    int c0;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(MulDivBusy), 32'd0);
    chk("rst_done", 32'(MulDivDone), 32'd0);
    chk("rst_count", 32'(StallCount), 32'd0);
    rst_n = 1'b1;
    settle();
    tick();

    // Load-use, then forward from MEM the following cycle
    RegWrite_E = 1'b1; MemtoReg_E = 1'b1; WriteReg_E = 5'd8; Rs_D = 5'd8;
    settle();
    chk("lw_stall", 32'(StallF), 32'd1);
    tick();
    clear_inputs();
    RegWrite_M = 1'b1; MemtoReg_M = 1'b1; WriteReg_M = 5'd8; Rs_E = 5'd8;
    settle();
    chk("lw_fwd", 32'(ForwardAE), 32'd2);
    chk("lw_nostall", 32'(StallD), 32'd0);
    chk("lw_count", 32'(StallCount), 32'd1);
    tick();

    // Forwarding priority
    clear_inputs();
    RegWrite_M = 1'b1; RegWrite_W = 1'b1; WriteReg_M = 5'd5; WriteReg_W = 5'd5; Rs_E = 5'd5;
    settle(); chk("prio_mem", 32'(ForwardAE), 32'd2);
    RegWrite_M = 1'b0;
    settle(); chk("prio_wb", 32'(ForwardAE), 32'd1);
    RegWrite_M = 1'b1; WriteReg_M = 5'd0; WriteReg_W = 5'd0; Rs_E = 5'd0;
    settle(); chk("prio_zero", 32'(ForwardAE), 32'd0);
    tick();

    // Branch hazard
    clear_inputs();
    Branch_D = 1'b1; PCSrc_D = 1'b1; Rs_D = 5'd3; RegWrite_E = 1'b1; WriteReg_E = 5'd3;
    settle();
    chk("br_stall", 32'(StallD), 32'd1);
    chk("br_noflush", 32'(FlushD), 32'd0);
    tick();
    RegWrite_E = 1'b0; WriteReg_E = 5'd0; RegWrite_M = 1'b1; WriteReg_M = 5'd3;
    settle();
    chk("br_fwdAD", 32'(ForwardAD), 32'd1);
    chk("br_flush", 32'(FlushD), 32'd1);
    tick();

    // Mul/div with mflo waiting in ID
    clear_inputs();
    MulDivStart_E = 1'b1;
    settle();
    tick();
    MulDivStart_E = 1'b0; HiLoRead_D = 1'b1;
    c0 = m_cnt;
    for (int i = 1; i <= LAT; i++) begin
      settle();
      chk("md_busy", 32'(MulDivBusy), 32'd1);
      chk("md_stall", 32'(StallD), 32'd1);
      tick();
    end
    settle();
    chk("md_done", 32'(MulDivDone), 32'd1);
    chk("md_idle", 32'(MulDivBusy), 32'd0);
    chk("md_count", 32'(StallCount), 32'(c0 + LAT));
    tick();

    // Jump
    clear_inputs();
    Jump_D = 1'b1;
    settle();
    chk("jmp_flush", 32'(FlushD), 32'd1);
    chk("jmp_nostall", 32'(StallF), 32'd0);
    tick();

    // Random traffic; never issue while the unit is busy
    for (int n = 0; n < 400; n++) begin
      Rs_D = 5'($urandom_range(0, 7)); Rt_D = 5'($urandom_range(0, 7));
      Rs_E = 5'($urandom_range(0, 7)); Rt_E = 5'($urandom_range(0, 7));
      WriteReg_E = 5'($urandom_range(0, 7)); WriteReg_M = 5'($urandom_range(0, 7));
      WriteReg_W = 5'($urandom_range(0, 7));
      RegWrite_E = 1'($urandom_range(0, 1)); RegWrite_M = 1'($urandom_range(0, 1));
      RegWrite_W = 1'($urandom_range(0, 1)); MemtoReg_E = 1'($urandom_range(0, 1));
      MemtoReg_M = 1'($urandom_range(0, 1)); Branch_D = 1'($urandom_range(0, 1));
      PCSrc_D = 1'($urandom_range(0, 1)); Jump_D = 1'($urandom_range(0, 3) == 0);
      MulDivStart_D = 1'($urandom_range(0, 3) == 0); HiLoRead_D = 1'($urandom_range(0, 3) == 0);
      MulDivStart_E = (m_busy_left == 0) && ($urandom_range(0, 5) == 0);
      settle();
      tick();
    end

    // Reset during BUSY
    clear_inputs();
    for (int i = 0; i < 20 && m_busy_left > 0; i++) tick();
    MulDivStart_E = 1'b1;
    settle(); tick();
    MulDivStart_E = 1'b0;
    settle(); tick();
    chk("pre_rst_busy", 32'(MulDivBusy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(MulDivBusy), 32'd0);
    chk("arst_done", 32'(MulDivDone), 32'd0);
    chk("arst_count", 32'(StallCount), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("arst_nodone", 32'(MulDivDone), 32'd0);
      tick();
    end

    // Saturation of the narrow counter
    RegWrite_E = 1'b1; MemtoReg_E = 1'b1; WriteReg_E = 5'd9; Rt_D = 5'd9;
    for (int i = 0; i < 20; i++) begin
      settle();
      tick();
    end
    clear_inputs();
    settle();
    chk("sat_count4", 32'(StallCount_b), 32'd15);
    chk("sat_count16", 32'(StallCount), 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
